// File: rtl/fa_response_checker.sv
// Full-adder response checker: golden {Carry,Sum}, latency-matched compare,
// saturating error count, coverage map and PASS/FAIL verdict.
// Optional build macro FA_CHK_STOP_ON_ERR_EN: first mismatch forces FAIL.
module fa_response_checker #(
    parameter int unsigned LATENCY = 0,
    parameter int unsigned ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic             A,
    input  logic             B,
    input  logic             Cin,
    input  logic             Sum,
    input  logic             Carry,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       cov_map,
    output logic             done,
    output logic             pass,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       cov_q, cov_d;

    logic       run;
    logic       samp_v;
    logic [1:0] exp_w;
    logic [2:0] idx_w;
    logic [1:0] obs_w;

    logic       cmp_v;
    logic [1:0] cmp_exp;
    logic [2:0] cmp_idx;
    logic       pipe_busy;

    assign run    = (state_q == S_RUN);
    // start wins over a coincident valid: that vector is dropped
    assign samp_v = valid & run & ~start;
    assign exp_w  = {1'b0, A} + {1'b0, B} + {1'b0, Cin};
    assign idx_w  = {A, B, Cin};
    assign obs_w  = {Carry, Sum};

    generate
        if (LATENCY == 0) begin : g_nopipe
            assign cmp_v     = samp_v;
            assign cmp_exp   = exp_w;
            assign cmp_idx   = idx_w;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            // LATENCY is expected in 1..4 on this branch
            logic [LATENCY-1:0] v_q;
            logic [1:0]         e_q [LATENCY];
            logic [2:0]         i_q [LATENCY];

            // expectation shift register; flushed on restart or outside RUN
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    for (int i = 0; i < int'(LATENCY); i++) begin
                        e_q[i] <= '0;
                        i_q[i] <= '0;
                    end
                end else if (start || !run) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= samp_v;
                    e_q[0] <= exp_w;
                    i_q[0] <= idx_w;
                    for (int i = 1; i < int'(LATENCY); i++) begin
                        v_q[i] <= v_q[i-1];
                        e_q[i] <= e_q[i-1];
                        i_q[i] <= i_q[i-1];
                    end
                end
            end

            assign cmp_v     = v_q[LATENCY-1] & run & ~start;
            assign cmp_exp   = e_q[LATENCY-1];
            assign cmp_idx   = i_q[LATENCY-1];
            assign pipe_busy = |v_q;
        end
    endgenerate

    // next-state: restart/clear, compare bookkeeping and verdict
    always_comb begin
        state_d    = state_q;
        mismatch_d = 1'b0;
        err_d      = err_q;
        cov_d      = cov_q;
        if (start) begin
            state_d = S_RUN;
            err_d   = '0;
            cov_d   = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (cmp_v) begin
                        cov_d[cmp_idx] = 1'b1;
                        if (obs_w != cmp_exp) begin
                            mismatch_d = 1'b1;
                            if (err_q != {ERR_W{1'b1}}) begin
                                err_d = err_q + ERR_W'(1);
                            end
`ifdef FA_CHK_STOP_ON_ERR_EN
                            state_d = S_FAIL;
`endif
                        end
                    end else if ((cov_q == 8'hFF) && !pipe_busy) begin
                        state_d = (err_q == '0) ? S_PASS : S_FAIL;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mismatch_q <= 1'b0;
            err_q      <= '0;
            cov_q      <= '0;
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            cov_q      <= cov_d;
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = err_q;
    assign cov_map  = cov_q;
    assign done     = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass     = (state_q == S_PASS);
    assign state    = state_q;

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench for fa_response_checker: golden, faulty and delayed DUT
// models drive four checker instances with differing LATENCY/ERR_W.
module tb_fa_response_checker;

`ifdef FA_CHK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic valid = 1'b0;
    logic A = 1'b0, B = 1'b0, Cin = 1'b0;
    logic stuck = 1'b0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    logic gs, gc;
    assign gs = A ^ B ^ Cin;
    assign gc = (A & B) | (A & Cin) | (B & Cin);

    logic [1:0] d1 = 2'b00, d2 = 2'b00;
    always @(posedge clk) begin
        d1 <= {gc, gs};
        d2 <= d1;
    end

    logic       m0, dn0, p0;
    logic [7:0] e0, cv0;
    logic [1:0] st0;
    logic       m2, dn2, p2;
    logic [7:0] e2, cv2;
    logic [1:0] st2;
    logic       m1, dn1, p1;
    logic [7:0] e1, cv1;
    logic [1:0] st1;
    logic       ms, dns, ps;
    logic [1:0] es;
    logic [7:0] cvs;
    logic [1:0] sts;

    fa_response_checker #(.LATENCY(0), .ERR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
        .A(A), .B(B), .Cin(Cin), .Sum(gs), .Carry(stuck ? 1'b0 : gc),
        .mismatch(m0), .err_cnt(e0), .cov_map(cv0), .done(dn0),
        .pass(p0), .state(st0)
    );

    fa_response_checker #(.LATENCY(2), .ERR_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
        .A(A), .B(B), .Cin(Cin), .Sum(d2[0]), .Carry(d2[1]),
        .mismatch(m2), .err_cnt(e2), .cov_map(cv2), .done(dn2),
        .pass(p2), .state(st2)
    );

    fa_response_checker #(.LATENCY(1), .ERR_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
        .A(A), .B(B), .Cin(Cin), .Sum(d2[0]), .Carry(d2[1]),
        .mismatch(m1), .err_cnt(e1), .cov_map(cv1), .done(dn1),
        .pass(p1), .state(st1)
    );

    fa_response_checker #(.LATENCY(0), .ERR_W(2)) us (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
        .A(A), .B(B), .Cin(Cin), .Sum(~gs), .Carry(gc),
        .mismatch(ms), .err_cnt(es), .cov_map(cvs), .done(dns),
        .pass(ps), .state(sts)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic apply_vec(input logic [2:0] v);
        {A, B, Cin} = v;
        valid = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        {A, B, Cin} = 3'b000;
        stuck = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if ({st0, e0, cv0, dn0, p0, m0} !== 21'd0) begin
            $display("FAIL reset_u0 got st=%0d err=%0d cov=%h done=%b pass=%b mis=%b want all 0",
                     st0, e0, cv0, dn0, p0, m0);
            nerr++;
        end
        nvec++;
        if ({st2, cv2, dn2} !== 11'd0) begin
            $display("FAIL reset_u2 got st=%0d cov=%h done=%b want 0", st2, cv2, dn2);
            nerr++;
        end
    endtask

    task automatic test_golden();
        stuck = 1'b0;
        {A, B, Cin} = 3'b000;
        pulse_start();
        for (int v = 0; v < 8; v++) begin
            apply_vec(3'(v));
            nvec++;
            if (m0 !== 1'b0) begin
                $display("FAIL golden_mis v=%0d got %b want 0", v, m0);
                nerr++;
            end
        end
        valid = 1'b0;
        nvec++;
        if (e0 !== 8'd0 || cv0 !== 8'hFF || st0 !== 2'd1 || dn0 !== 1'b0) begin
            $display("FAIL golden_last got err=%0d cov=%h st=%0d done=%b want 0 ff 1 0",
                     e0, cv0, st0, dn0);
            nerr++;
        end
        tick();
        nvec++;
        if (st0 !== 2'd2 || dn0 !== 1'b1 || p0 !== 1'b1) begin
            $display("FAIL golden_verdict got st=%0d done=%b pass=%b want 2 1 1",
                     st0, dn0, p0);
            nerr++;
        end
    endtask

    task automatic test_stuck_carry();
        logic [7:0] cmask;
        logic       em;
        cmask = 8'b1110_1000;
        stuck = 1'b1;
        pulse_start();
        for (int v = 0; v < 8; v++) begin
            apply_vec(3'(v));
            em = STOP ? (v == 3) : cmask[v];
            nvec++;
            if (m0 !== em) begin
                $display("FAIL stuck_mis v=%0d got %b want %b", v, m0, em);
                nerr++;
            end
        end
        valid = 1'b0;
        tick();
        nvec++;
        if (e0 !== (STOP ? 8'd1 : 8'd4) || cv0 !== (STOP ? 8'h0F : 8'hFF)) begin
            $display("FAIL stuck_cnt got err=%0d cov=%h want %0d %h", e0, cv0,
                     STOP ? 1 : 4, STOP ? 8'h0F : 8'hFF);
            nerr++;
        end
        nvec++;
        if (st0 !== 2'd3 || dn0 !== 1'b1 || p0 !== 1'b0) begin
            $display("FAIL stuck_verdict got st=%0d done=%b pass=%b want 3 1 0",
                     st0, dn0, p0);
            nerr++;
        end
        stuck = 1'b0;
    endtask

    task automatic test_latency();
        {A, B, Cin} = 3'b000;
        tick();
        pulse_start();
        for (int v = 0; v < 8; v++) begin
            apply_vec(3'(v));
        end
        valid = 1'b0;
        tick();
        tick();
        tick();
        nvec++;
        if (e2 !== 8'd0 || cv2 !== 8'hFF || st2 !== 2'd2 || p2 !== 1'b1) begin
            $display("FAIL lat2_pass got err=%0d cov=%h st=%0d pass=%b want 0 ff 2 1",
                     e2, cv2, st2, p2);
            nerr++;
        end
        nvec++;
        if (e1 === 8'd0 || st1 !== 2'd3 || dn1 !== 1'b1) begin
            $display("FAIL lat1_fail got err=%0d st=%0d done=%b want err>0 3 1",
                     e1, st1, dn1);
            nerr++;
        end
    endtask

    task automatic test_coverage();
        logic [2:0] seq [9];
        seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0, 3'd0};
        stuck = 1'b0;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            apply_vec(seq[i]);
        end
        valid = 1'b0;
        tick();
        tick();
        nvec++;
        if (cv0 !== 8'hBF || st0 !== 2'd1 || dn0 !== 1'b0 || e0 !== 8'd0) begin
            $display("FAIL cov_partial got cov=%h st=%0d done=%b err=%0d want bf 1 0 0",
                     cv0, st0, dn0, e0);
            nerr++;
        end
    endtask

    task automatic test_restart();
        stuck = 1'b1;
        pulse_start();
        apply_vec(3'd3);
        apply_vec(3'd5);
        apply_vec(3'd6);
        nvec++;
        if (e0 !== (STOP ? 8'd1 : 8'd3)) begin
            $display("FAIL restart_pre got err=%0d want %0d", e0, STOP ? 1 : 3);
            nerr++;
        end
        {A, B, Cin} = 3'b111;
        start = 1'b1;
        valid = 1'b1;
        tick();
        start = 1'b0;
        valid = 1'b0;
        nvec++;
        if (e0 !== 8'd0 || cv0 !== 8'd0 || st0 !== 2'd1 || m0 !== 1'b0) begin
            $display("FAIL restart_clr got err=%0d cov=%h st=%0d mis=%b want 0 0 1 0",
                     e0, cv0, st0, m0);
            nerr++;
        end
        tick();
        nvec++;
        if (cv0 !== 8'd0 || e0 !== 8'd0) begin
            $display("FAIL restart_drop got cov=%h err=%0d want 0 0", cv0, e0);
            nerr++;
        end
        do_reset();
        apply_vec(3'd0);
        apply_vec(3'd1);
        apply_vec(3'd2);
        valid = 1'b0;
        tick();
        nvec++;
        if (cv0 !== 8'd0 || st0 !== 2'd0 || e0 !== 8'd0) begin
            $display("FAIL idle_valid got cov=%h st=%0d err=%0d want 0 0 0",
                     cv0, st0, e0);
            nerr++;
        end
    endtask

    task automatic test_reset_midrun();
        stuck = 1'b1;
        pulse_start();
        apply_vec(3'd3);
        apply_vec(3'd5);
        valid = 1'b0;
        nvec++;
        if (e0 !== (STOP ? 8'd1 : 8'd2) || cv0 === 8'd0) begin
            $display("FAIL midrun_pre got err=%0d cov=%h want %0d nonzero",
                     e0, cv0, STOP ? 1 : 2);
            nerr++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({st0, e0, cv0, dn0, p0, m0} !== 21'd0) begin
            $display("FAIL midrun_rst got st=%0d err=%0d cov=%h done=%b pass=%b mis=%b want all 0",
                     st0, e0, cv0, dn0, p0, m0);
            nerr++;
        end
        tick();
        rst_n = 1'b1;
        stuck = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        logic em;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            apply_vec(3'd0);
            em = STOP ? (i == 0) : 1'b1;
            nvec++;
            if (ms !== em) begin
                $display("FAIL sat_mis i=%0d got %b want %b", i, ms, em);
                nerr++;
            end
        end
        valid = 1'b0;
        nvec++;
        if (es !== (STOP ? 2'd1 : 2'd3) || sts !== (STOP ? 2'd3 : 2'd1)) begin
            $display("FAIL sat_cnt got err=%0d st=%0d want %0d %0d", es, sts,
                     STOP ? 1 : 3, STOP ? 3 : 1);
            nerr++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_golden();
        test_stuck_carry();
        test_latency();
        test_coverage();
        test_restart();
        test_reset_midrun();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
